// File: rtl/ahblite_pkg.sv
// ahblite_pkg: shared AHB-Lite encodings, default-slave states and the default memory map
package ahblite_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_t;
    localparam logic [31:0] RAMCODE_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAMDATA_BASE    = 32'h2000_0000;
    localparam logic [31:0] WATERLIGHT_BASE = 32'h4000_0000;
    localparam logic [31:0] UART_BASE       = 32'h4000_0010;
    localparam logic [31:0] GPIO_BASE       = 32'h4000_0020;
    localparam logic [31:0] RAM_MASK        = 32'hFFFF_0000;
    localparam logic [31:0] PERIPH_MASK     = 32'hFFFF_FFF0;
endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave: two-cycle ERROR responder for unmapped active transfers with error counter
module ahblite_default_slave
    import ahblite_pkg::*;
#(
    parameter int ERRCNT_W = 16
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HREADY,
    input  logic                sel_err,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic                decode_err,
    output logic [ERRCNT_W-1:0] err_count
);
    ds_state_t r_state, w_next;
    logic r_decode_err;
    logic [ERRCNT_W-1:0] r_count;
    // state register
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) r_state <= DS_IDLE;
        else r_state <= w_next;
    // ERR1 always advances; otherwise a new unmapped active transfer starts (or restarts) the error
    always_comb w_next = (r_state == DS_ERR1) ? DS_ERR2 : (HREADY && sel_err) ? DS_ERR1 : DS_IDLE;
    // first error cycle stalls, both error cycles signal ERROR
    always_comb begin
        HREADYOUT = (r_state != DS_ERR1);
        HRESP     = (r_state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
    end
    // pulse and saturating count on every ERR1 entry
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            r_decode_err <= 1'b0;
            r_count      <= '0;
        end else begin
            r_decode_err <= (w_next == DS_ERR1);
            if (w_next == DS_ERR1 && !(&r_count)) r_count <= r_count + ERRCNT_W'(1);
        end
    assign decode_err = r_decode_err;
    assign err_count  = r_count;
endmodule

// File: rtl/ahblite_decoder_mux.sv
// ahblite_decoder_mux: AHB-Lite address decoder, data-phase response mux and default slave
module ahblite_decoder_mux
    import ahblite_pkg::*;
#(
    parameter int                        NUM_PORTS = 5,
    parameter logic [NUM_PORTS-1:0]      PORT_EN   = 5'b10011,
    parameter logic [32*NUM_PORTS-1:0]   PORT_BASE = {GPIO_BASE, UART_BASE, WATERLIGHT_BASE, RAMDATA_BASE, RAMCODE_BASE},
    parameter logic [32*NUM_PORTS-1:0]   PORT_MASK = {PERIPH_MASK, PERIPH_MASK, PERIPH_MASK, RAM_MASK, RAM_MASK},
    parameter int                        ERRCNT_W  = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [31:0]            HADDR,
    input  logic [1:0]             HTRANS,
    output logic [NUM_PORTS-1:0]   HSEL,
    input  logic [NUM_PORTS-1:0]   HREADYOUT_S,
    input  logic [NUM_PORTS-1:0]   HRESP_S,
    input  logic [32*NUM_PORTS-1:0] HRDATA_S,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [31:0]            HRDATA,
    output logic                   decode_err,
    output logic [ERRCNT_W-1:0]    err_count
);
    logic [NUM_PORTS-1:0] w_hit, w_hsel, r_sel;
    logic r_dflt, r_act, w_active, w_ds_ready, w_ds_resp;
    logic [31:0] w_rdata;
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dec
        assign w_hit[i] = PORT_EN[i] & ((HADDR & PORT_MASK[32*i +: 32]) == PORT_BASE[32*i +: 32]);
    end
    // keeping only the lowest set bit gives lowest-index priority on overlaps
    assign w_hsel   = w_hit & (~w_hit + NUM_PORTS'(1));
    assign HSEL     = w_hsel;
    assign w_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    // capture the address-phase decision into the data phase
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            r_sel  <= '0;
            r_dflt <= 1'b0;
            r_act  <= 1'b0;
        end else if (HREADY) begin
            r_sel  <= w_hsel;
            r_dflt <= (w_hsel == '0);
            r_act  <= w_active;
        end
    ahblite_default_slave #(.ERRCNT_W(ERRCNT_W)) u_dflt (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .HREADY(HREADY),
        .sel_err((w_hsel == '0) && w_active),
        .HREADYOUT(w_ds_ready),
        .HRESP(w_ds_resp),
        .decode_err(decode_err),
        .err_count(err_count)
    );
    // one-hot read-data mux, zero when no slave port owns the data phase
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < NUM_PORTS; k++) w_rdata = w_rdata | (HRDATA_S[32*k +: 32] & {32{r_sel[k]}});
    end
    // an inactive unmapped data phase is always zero-wait OKAY, matching the idle default slave
    always_comb begin
        HREADY = (|r_sel) ? |(r_sel & HREADYOUT_S) : (r_dflt && r_act) ? w_ds_ready : 1'b1;
        HRESP  = (|r_sel) ? |(r_sel & HRESP_S) : (r_dflt && r_act) ? w_ds_resp : HRESP_OKAY;
        HRDATA = w_rdata;
    end
endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// tb_ahblite_decoder_mux: directed plus randomized checks against a transaction-level bus model
module tb_ahblite_decoder_mux;
    import ahblite_pkg::*;
    localparam int N = 5;
    logic HCLK = 1'b0, HRESETn;
    logic [31:0] HADDR;
    logic [1:0] HTRANS;
    logic [N-1:0] HSEL, HSEL2, HREADYOUT_S, HRESP_S;
    logic [32*N-1:0] HRDATA_S;
    logic HREADY, HRESP, decode_err, HREADY2, HRESP2, derr2;
    logic [31:0] HRDATA, HRDATA2;
    logic [15:0] err_count;
    logic [1:0] cnt2;
    logic [31:0] m_base [N] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h4000_0010, 32'h4000_0020};
    logic [31:0] m_mask [N] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    bit m_en [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int m_owner, m_ph, m_cnt, m_cnt2;
    bit m_pulse;
    int n_vec = 0, n_bad = 0;
    logic o_ready, o_resp;
    logic [31:0] o_data, o_cnt, o_cnt2;

    ahblite_decoder_mux dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .decode_err(decode_err), .err_count(err_count)
    );
    ahblite_decoder_mux #(.ERRCNT_W(2)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL2),
        .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
        .HREADY(HREADY2), .HRESP(HRESP2), .HRDATA(HRDATA2), .decode_err(derr2), .err_count(cnt2)
    );

    always #5 HCLK = ~HCLK;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) if (m_en[i] && ((a & m_mask[i]) == m_base[i])) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ph = 0; m_cnt = 0; m_cnt2 = 0; m_pulse = 0;
    endtask

    // one bus cycle: drive, check mid-cycle against the model, then advance the model at the edge
    task automatic apply(input logic [31:0] a, input logic [1:0] t, input logic [N-1:0] ro);
        int d;
        logic [31:0] ehs, ed;
        logic er, ep;
        bit err;
        HADDR = a; HTRANS = t; HREADYOUT_S = ro;
        #3;
        d = decode(a);
        ehs = (d < 0) ? 32'd0 : (32'd1 << d);
        if (m_owner >= 0 && m_owner < N) begin
            er = HREADYOUT_S[m_owner]; ep = HRESP_S[m_owner]; ed = HRDATA_S[32*m_owner +: 32];
        end else if (m_owner == N) begin
            er = (m_ph != 1); ep = (m_ph != 0); ed = 32'd0;
        end else begin
            er = 1'b1; ep = 1'b0; ed = 32'd0;
        end
        o_ready = HREADY; o_resp = HRESP; o_data = HRDATA; o_cnt = 32'(err_count); o_cnt2 = 32'(cnt2);
        chk("hsel", 32'(HSEL), ehs);
        chk("hready", 32'(HREADY), 32'(er));
        chk("hresp", 32'(HRESP), 32'(ep));
        chk("hrdata", HRDATA, ed);
        chk("decode_err", 32'(decode_err), 32'(m_pulse));
        chk("err_count", 32'(err_count), m_cnt);
        chk("err_count_w2", 32'(cnt2), m_cnt2);
        chk("decode_err_w2", 32'(derr2), 32'(m_pulse));
        @(posedge HCLK);
        if (m_ph == 1) begin
            m_ph = 2; m_pulse = 0;
        end else if (er) begin
            err = (d < 0) && t[1];
            m_owner = (d < 0) ? N : d;
            m_ph = err ? 1 : 0;
            m_pulse = err;
            if (err) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
            end
        end else m_pulse = 0;
        #1;
    endtask

    initial begin
        logic [31:0] addrs [6];
        logic [N-1:0] ro;
        HRESETn = 1'b0; HADDR = 32'h0; HTRANS = HTRANS_IDLE; HREADYOUT_S = '1; HRESP_S = '0;
        for (int i = 0; i < N; i++) HRDATA_S[32*i +: 32] = $urandom;
        model_reset();
        #2;
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_decode_err", 32'(decode_err), 32'd0);
        chk("rst_hsel", 32'(HSEL), 32'd1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        // mapped read from RAMDATA
        HRDATA_S[63:32] = 32'hCAFEF00D;
        apply(32'h2000_0004, HTRANS_NONSEQ, '1);
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t1_data", o_data, 32'hCAFEF00D);
        chk("t1_ready", 32'(o_ready), 32'd1);
        // GPIO with three wait states while the next address points elsewhere
        apply(32'h4000_0024, HTRANS_NONSEQ, '1);
        for (int i = 0; i < 3; i++) begin
            apply(32'h2000_0000, HTRANS_NONSEQ, 5'b01111);
            chk("t2_stall", 32'(o_ready), 32'd0);
            chk("t2_hold_data", o_data, HRDATA_S[159:128]);
        end
        apply(32'h2000_0000, HTRANS_NONSEQ, '1);
        chk("t2_done", 32'(o_ready), 32'd1);
        apply(32'h0, HTRANS_IDLE, '1);
        // disabled WaterLight port gives a two-cycle error
        apply(32'h4000_0000, HTRANS_NONSEQ, '1);
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t3_err1", {o_ready, o_resp}, 32'b01);
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t3_err2", {o_ready, o_resp}, 32'b11);
        chk("t3_count", o_cnt, 32'd1);
        // unmapped IDLE transfer is zero-wait OKAY
        apply(32'h5000_0000, HTRANS_IDLE, '1);
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t4_okay", {o_ready, o_resp}, 32'b10);
        chk("t4_count", o_cnt, 32'd1);
        // back-to-back errors with the second issued in ERR2
        apply(32'h5000_0000, HTRANS_NONSEQ, '1);
        apply(32'h6000_0000, HTRANS_NONSEQ, '1);
        apply(32'h6000_0000, HTRANS_NONSEQ, '1);
        chk("t5_first_err2", {o_ready, o_resp}, 32'b11);
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t5_second_err1", {o_ready, o_resp}, 32'b01);
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t5_count", o_cnt, 32'd3);
        for (int i = 0; i < 2; i++) begin
            apply(32'h7000_0000, HTRANS_SEQ, '1);
            apply(32'h0, HTRANS_IDLE, '1);
            apply(32'h0, HTRANS_IDLE, '1);
        end
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t5_count5", o_cnt, 32'd5);
        chk("t5_saturated", o_cnt2, 32'd3);
        // asynchronous reset in the middle of ERR1
        apply(32'h5000_0000, HTRANS_NONSEQ, '1);
        HRESETn = 1'b0;
        #1;
        chk("t6_hready", 32'(HREADY), 32'd1);
        chk("t6_hresp", 32'(HRESP), 32'd0);
        chk("t6_hrdata", HRDATA, 32'd0);
        chk("t6_count", 32'(err_count), 32'd0);
        chk("t6_hsel", 32'(HSEL), 32'd0);
        model_reset();
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        apply(32'h0000_0010, HTRANS_NONSEQ, '1);
        apply(32'h0, HTRANS_IDLE, '1);
        chk("t6_after", {o_ready, o_resp}, 32'b10);
        chk("t6_after_data", o_data, HRDATA_S[31:0]);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            addrs[0] = {16'h0000, 16'($urandom)};
            addrs[1] = {16'h2000, 16'($urandom)};
            addrs[2] = {28'h4000000, 4'($urandom)};
            addrs[3] = {28'h4000001, 4'($urandom)};
            addrs[4] = {28'h4000002, 4'($urandom)};
            addrs[5] = $urandom;
            for (int i = 0; i < N; i++) begin
                ro[i] = ($urandom_range(3) != 0);
                HRDATA_S[32*i +: 32] = $urandom;
            end
            HRESP_S = N'($urandom);
            apply(addrs[$urandom_range(5)], 2'($urandom), ro);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
